// File: rtl/mod_arbiter.sv
// mod_arbiter: two-requester round-robin front end for a shared
// repeated-subtraction modulo unit. The winning requester's operands are
// latched, A mod B is computed by iterated subtraction, and the remainder
// is returned with a one-cycle done pulse routed to the owning requester.
`timescale 1ns/1ps

module mod_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] rem_r, rem_nxt_s;
  logic [WIDTH-1:0] div_r, div_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic             owner_r, owner_nxt_s;
  // last_r remembers who was served most recently; resetting it to 1
  // makes requester 0 win the first contention.
  logic             last_r, last_nxt_s;
  logic             sel_s;
  logic             gnt0_r, gnt0_nxt_s;
  logic             gnt1_r, gnt1_nxt_s;
  logic             done0_r, done0_nxt_s;
  logic             done1_r, done1_nxt_s;
  logic             err_r, err_nxt_s;
  logic             busy_r, busy_nxt_s;

  assign gnt0   = gnt0_r;
  assign gnt1   = gnt1_r;
  assign done0  = done0_r;
  assign done1  = done1_r;
  assign result = result_r;
  assign err    = err_r;
  assign busy   = busy_r;

  // Round-robin pick: a lone request wins, contention goes to the requester not served last.
  always_comb begin
    if (req0 && req1) begin
      sel_s = ~last_r;
    end else if (req1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Next-state and next-output logic; pulses default low, data registers hold.
  always_comb begin
    state_nxt_s  = state_r;
    rem_nxt_s    = rem_r;
    div_nxt_s    = div_r;
    result_nxt_s = result_r;
    owner_nxt_s  = owner_r;
    last_nxt_s   = last_r;
    err_nxt_s    = err_r;
    gnt0_nxt_s   = 1'b0;
    gnt1_nxt_s   = 1'b0;
    done0_nxt_s  = 1'b0;
    done1_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          rem_nxt_s   = sel_s ? a1 : a0;
          div_nxt_s   = sel_s ? b1 : b0;
          owner_nxt_s = sel_s;
          last_nxt_s  = sel_s;
          state_nxt_s = SUB;
          if (sel_s) begin
            gnt1_nxt_s = 1'b1;
          end else begin
            gnt0_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SUB: begin
        if ((div_r == {WIDTH{1'b0}}) || (rem_r < div_r)) begin
          // Divide-by-zero returns the untouched dividend with err set.
          state_nxt_s  = DONE;
          err_nxt_s    = (div_r == {WIDTH{1'b0}});
          result_nxt_s = rem_r;
          if (owner_r) begin
            done1_nxt_s = 1'b1;
          end else begin
            done0_nxt_s = 1'b1;
          end
        end else begin
          // rem_r >= div_r here, so the subtraction cannot wrap.
          rem_nxt_s   = rem_r - div_r;
          state_nxt_s = SUB;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State, datapath and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      rem_r    <= {WIDTH{1'b0}};
      div_r    <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
      err_r    <= 1'b0;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rem_r    <= rem_nxt_s;
      div_r    <= div_nxt_s;
      result_r <= result_nxt_s;
      owner_r  <= owner_nxt_s;
      last_r   <= last_nxt_s;
      err_r    <= err_nxt_s;
      gnt0_r   <= gnt0_nxt_s;
      gnt1_r   <= gnt1_nxt_s;
      done0_r  <= done0_nxt_s;
      done1_r  <= done1_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_mod_arbiter.sv
// tb_mod_arbiter: table-driven directed vectors, hand-written corner-case
// sequences and randomized transactions checked against a behavioural model
// of the arbiter (remainder via %, latency via /, round-robin via last-served).
`timescale 1ns/1ps

module tb_mod_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1, err, busy;
  logic [WIDTH-1:0] result;

  int total;
  int bad;
  int last_srv;

  mod_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int             who;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_res;
    logic           exp_err;
    int             exp_lat;
  } vec_t;

  vec_t vecs [8];

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_rem(input int a, input int b);
    return (b == 0) ? WIDTH'(a) : WIDTH'(a % b);
  endfunction

  function automatic int ref_lat(input int a, input int b);
    return (b == 0) ? 2 : (a / b) + 2;
  endfunction

  function automatic int ref_pick(input int r0, input int r1);
    if (r0 != 0 && r1 != 0) return (last_srv == 0) ? 1 : 0;
    return (r1 != 0) ? 1 : 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_gnt0"}, gnt0, 0);
    chk({name, "_gnt1"}, gnt1, 0);
    chk({name, "_done0"}, done0, 0);
    chk({name, "_done1"}, done1, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_result"}, result, 0);
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    last_srv = 1;
  endtask

  // Waits for a grant, checks which one and how many edges it took, then
  // drops the winner's request unless keep is set.
  task automatic wait_gnt(input int exp_who, input int exp_wait, input bit keep, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(gnt0 || gnt1) && n < 50);
    chk({name, "_gnt_wait"}, n, exp_wait);
    chk({name, "_gnt0"}, gnt0, (exp_who == 0));
    chk({name, "_gnt1"}, gnt1, (exp_who == 1));
    chk({name, "_busy_on_gnt"}, busy, 1);
    if (!keep) begin
      if (exp_who == 0) req0 = 1'b0;
      else              req1 = 1'b0;
    end
    last_srv = exp_who;
  endtask

  // Starting n0 cycles after the sampling edge, waits for done and checks
  // latency, routing and the returned remainder/error.
  task automatic wait_done(input int who, input logic [WIDTH-1:0] exp_res, input logic exp_err,
                           input int exp_lat, input int n0, input string name);
    int  n = n0;
    bit  extra_gnt = 1'b0;
    while (!(done0 || done1) && n < 300) begin
      @(posedge clk); #1; n++;
      if (gnt0 || gnt1) extra_gnt = 1'b1;
    end
    chk({name, "_no_gnt_while_busy"}, extra_gnt, 0);
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_done0"}, done0, (who == 0));
    chk({name, "_done1"}, done1, (who == 1));
    chk({name, "_result"}, result, exp_res);
    chk({name, "_err"}, err, exp_err);
  endtask

  task automatic single(input int who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input logic exp_err, input int exp_lat,
                        input string name);
    if (who == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else          begin req1 = 1'b1; a1 = a; b1 = b; end
    wait_gnt(who, 1, 1'b0, name);
    // Operand changes after the grant must not matter.
    if (who == 0) begin a0 = ~a; b0 = b + 8'd1; end
    else          begin a1 = ~a; b1 = b + 8'd1; end
    wait_done(who, exp_res, exp_err, exp_lat, 1, name);
    @(posedge clk); #1;
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_done_cleared"}, done0 | done1, 0);
  endtask

  initial begin
    bit saw_done;
    total = 0; bad = 0; last_srv = 1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    reset = 1'b1;
    #2;

    vecs[0] = '{0, 8'd17,  8'd5,   8'd2,  1'b0, 5};
    vecs[1] = '{1, 8'd3,   8'd9,   8'd3,  1'b0, 2};
    vecs[2] = '{0, 8'd42,  8'd0,   8'd42, 1'b1, 2};
    vecs[3] = '{1, 8'd0,   8'd7,   8'd0,  1'b0, 2};
    vecs[4] = '{0, 8'd200, 8'd200, 8'd0,  1'b0, 3};
    vecs[5] = '{1, 8'd255, 8'd16,  8'd15, 1'b0, 17};
    vecs[6] = '{0, 8'd100, 8'd7,   8'd2,  1'b0, 16};
    vecs[7] = '{1, 8'd9,   8'd1,   8'd0,  1'b0, 11};

    do_reset();

    // Directed single-request vectors.
    for (int i = 0; i < 8; i++) begin
      single(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_err,
             vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Contention with both requests held high: grants alternate 0,1,0,1.
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'd10; b0 = 8'd3; a1 = 8'd10; b1 = 8'd3;
    for (int i = 0; i < 4; i++) begin
      int exp_who;
      exp_who = ref_pick(1, 1);
      chk($sformatf("cont%0d_order", i), exp_who, i % 2);
      wait_gnt(exp_who, (i == 0) ? 1 : 2, 1'b1, $sformatf("cont%0d", i));
      wait_done(exp_who, 8'd1, 1'b0, 5, 1, $sformatf("cont%0d", i));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk("cont_idle_busy", busy, 0);

    // Worst case 255 mod 1; req1 arrives mid-operation and must wait.
    req0 = 1'b1; a0 = 8'd255; b0 = 8'd1;
    wait_gnt(0, 1, 1'b0, "worst");
    repeat (5) begin @(posedge clk); #1; end
    req1 = 1'b1; a1 = 8'd7; b1 = 8'd2;
    wait_done(0, 8'd0, 1'b0, 257, 6, "worst");
    wait_gnt(1, 2, 1'b0, "late1");
    wait_done(1, 8'd1, 1'b0, 5, 1, "late1");
    @(posedge clk); #1;

    // Reset in the middle of a long operation: no done, outputs cleared at once.
    req0 = 1'b1; a0 = 8'd200; b0 = 8'd3;
    wait_gnt(0, 1, 1'b0, "abort");
    saw_done = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (done0 || done1) saw_done = 1'b1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) begin
      @(posedge clk); #1;
      if (done0 || done1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    reset = 1'b1;
    last_srv = 1;
    req1 = 1'b1; a1 = 8'd9; b1 = 8'd4;
    wait_gnt(ref_pick(0, 1), 1, 1'b0, "post_reset");
    wait_done(1, 8'd1, 1'b0, 4, 1, "post_reset");
    @(posedge clk); #1;

    // After reset the pointer favours requester 0 under contention.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'd5; b0 = 8'd2; a1 = 8'd6; b1 = 8'd4;
    wait_gnt(ref_pick(1, 1), 1, 1'b0, "ptr_first");
    wait_done(0, 8'd1, 1'b0, 4, 1, "ptr_first");
    wait_gnt(1, 2, 1'b0, "ptr_second");
    wait_done(1, 8'd2, 1'b0, 3, 1, "ptr_second");
    @(posedge clk); #1;

    // Randomized rounds: one or both requesters, checked against the model.
    for (int k = 0; k < 40; k++) begin
      int pat, first, second;
      int ra0, rb0, ra1, rb1;
      pat = $urandom_range(1, 3);
      ra0 = $urandom_range(0, 255); rb0 = $urandom_range(0, 20);
      ra1 = $urandom_range(0, 255); rb1 = $urandom_range(0, 20);
      a0 = WIDTH'(ra0); b0 = WIDTH'(rb0); a1 = WIDTH'(ra1); b1 = WIDTH'(rb1);
      req0 = pat[0]; req1 = pat[1];
      first = ref_pick(pat & 1, (pat >> 1) & 1);
      wait_gnt(first, 1, 1'b0, $sformatf("rnd%0d_a", k));
      if (first == 0) begin
        a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
        wait_done(0, ref_rem(ra0, rb0), (rb0 == 0), ref_lat(ra0, rb0), 1, $sformatf("rnd%0d_a", k));
      end else begin
        a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
        wait_done(1, ref_rem(ra1, rb1), (rb1 == 0), ref_lat(ra1, rb1), 1, $sformatf("rnd%0d_a", k));
      end
      if (pat == 3) begin
        second = 1 - first;
        wait_gnt(second, 2, 1'b0, $sformatf("rnd%0d_b", k));
        if (second == 0)
          wait_done(0, ref_rem(ra0, rb0), (rb0 == 0), ref_lat(ra0, rb0), 1, $sformatf("rnd%0d_b", k));
        else
          wait_done(1, ref_rem(ra1, rb1), (rb1 == 0), ref_lat(ra1, rb1), 1, $sformatf("rnd%0d_b", k));
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_idle", k), busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_arbiter.md
Name: mod_arbiter

Overview:
- Shares one repeated-subtraction modulo datapath between two requesters.
- Round-robin arbitration picks a requester; the block latches that requester's A/B operands and computes A mod B by iterated subtraction.
- Returns the remainder with a one-cycle done pulse routed to the owning requester.
- Sits between client blocks and the modulo unit; it owns the control sequencing and the remainder/divisor registers.

Parameters:
WIDTH, 8, operand and result width in bits

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 request (level)
a0  input  WIDTH  requester 0 dividend
b0  input  WIDTH  requester 0 divisor
req1  input  1  requester 1 request (level)
a1  input  WIDTH  requester 1 dividend
b1  input  WIDTH  requester 1 divisor
gnt0  output  1  one-cycle pulse: requester 0 operands were captured
gnt1  output  1  one-cycle pulse: requester 1 operands were captured
done0  output  1  one-cycle pulse: requester 0 result is valid
done1  output  1  one-cycle pulse: requester 1 result is valid
result  output  WIDTH  remainder; holds its value until the next completion
err  output  1  divide-by-zero flag; valid while done0/done1 is high
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; gnt0/1, done0/1, err, busy = 0; result=0.
  - Internal rem/div registers = 0; owner=0.
  - Priority pointer set so that req0 wins the first contention.
  - A reset mid-operation aborts the operation immediately; no done pulse is issued for it.
- States: IDLE, SUB, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: select that requester.
  - Both requests: select the requester NOT served most recently.
  - On the selecting edge: rem<=a_sel, div<=b_sel, owner<=sel, pointer updated, state<=SUB, gnt_sel<=1.
  - gnt is therefore high during the first SUB cycle only.
- SUB, evaluated each cycle in this priority order:
  - div==0: state<=DONE, err<=1, result<=rem (the unmodified A).
  - else rem<div: state<=DONE, err<=0, result<=rem.
  - else rem<=rem-div (WIDTH-bit, never underflows because rem>=div), stay in SUB.
- DONE (one cycle):
  - done_owner=1 and result/err valid; state<=IDLE.
  - done and gnt are registered outputs, cleared in all other cycles.
- Latency:
  - SUB cycles = floor(A/B)+1 for B!=0, and 1 for B==0.
  - done rises the cycle after the last SUB cycle.
  - Total from sampling edge to done = floor(A/B)+2 cycles.
- Handshake:
  - A requester holds req, a, b stable until it sees gnt.
  - After gnt it must deassert req before the block returns to IDLE (at least 2 cycles later).
  - A req still high in IDLE is treated as a new request.
  - Operand changes after gnt have no effect.
- Requests arriving while busy are ignored until IDLE; arbitration happens only in IDLE.
- A=0, B!=0: one SUB cycle, result=0.
- A<B: one SUB cycle, result=A.
- Worst case A=2^WIDTH-1, B=1: 2^WIDTH SUB cycles.
- busy is high in SUB and DONE.

Test Plan:
- Reset, then req0=1, a0=17, b0=5 -> gnt0 pulse in the next cycle; 4 SUB cycles; done0=1 with result=2, err=0; busy low afterwards.
- req1 only, a1=3, b1=9 -> gnt1; one SUB cycle; done1 with result=3; done0 stays 0.
- Divide-by-zero: req0, a0=42, b0=0 -> done0 with err=1, result=42 after exactly one SUB cycle.
- Contention: req0 and req1 held high continuously (both re-asserting after each done), each with a=10, b=3 -> grants alternate gnt0, gnt1, gnt0, gnt1; each done returns result=1 to the matching requester.
- Worst case: a0=255, b0=1 -> done0 257 cycles after the sampling edge, result=0; req1 asserted mid-operation is served only after that done.
- Mid-operation reset: a0=200, b0=3; pull reset low after 10 SUB cycles -> all outputs 0 immediately, no done pulse; after release, req1 wins the arbitration (pointer reset favours req0, and req0 is now low).
